phone_dial_sequencer: RTL and testbench
=======================================

Name: phone_dial_sequencer

Overview:
Controller that plays out a stored 10-digit phone number, one digit at a time, to a downstream consumer such as a tone generator or display driver. It uses a valid/ready handshake and enforces a programmable inter-digit gap. It owns the digit store and the digit index counter, accepts runtime digit rewrites, and reports busy/done/error status to the host logic.

Parameters:
NUM_DIGITS, 10, number of digits in the stored number (index width 4 bits; max 16)
GAP_CYCLES, 4, idle cycles between digits with digit_valid low; legal range 1..255
DIGIT_W, 4, width of one BCD digit

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin playback; sampled only in IDLE
abort  in  1  cancel playback; sampled in any non-IDLE state
wr_en  in  1  digit-store write strobe
wr_idx  in  4  store index to write
wr_digit  in  DIGIT_W  BCD value to write
digit  out  DIGIT_W  current digit; 0 whenever digit_valid=0
digit_valid  out  1  digit presented to consumer
digit_ready  in  1  consumer accepts digit
idx  out  4  index of digit being presented or next to present
busy  out  1  high from the cycle after an accepted start until DONE
done  out  1  one-cycle pulse after the last digit is transferred
err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset values: state IDLE, digit_valid=0, digit=0, idx=0, busy=0, done=0, err=0, gap counter=0.
- Reset loads the store with DEFAULT_NUMBER = 9,8,6,6,5,6,2,4,1,8 (index 0 first).
- Reset mid-playback is equivalent to power-up. Any store writes are lost.
- The state register is one of four states: IDLE, PRESENT, GAP, DONE.
- IDLE:
  - start=1 in cycle N: PRESENT at edge N+1, idx=0, busy=1. digit_valid is high from cycle N+1.
  - start is ignored outside IDLE.
- PRESENT:
  - digit_valid=1 and digit=store[idx]. Both are held stable until transfer.
  - A transfer occurs when digit_valid and digit_ready are both high in the same cycle.
  - On transfer with idx<NUM_DIGITS-1: idx increments, the gap counter loads GAP_CYCLES, and the state goes to GAP.
  - On transfer with idx==NUM_DIGITS-1: the state goes to DONE.
- GAP:
  - digit_valid=0 and the counter decrements each cycle.
  - When the counter reaches 1, the state goes to PRESENT.
  - This gives exactly GAP_CYCLES low cycles between the transfer cycle and the next valid cycle.
- DONE (lasts one cycle):
  - done=1, busy=0, idx cleared to 0.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored.
- abort:
  - In PRESENT or GAP, abort=1 forces IDLE at the next edge: digit_valid=0, busy=0, idx=0, no done pulse.
  - Abort has priority over a simultaneous transfer; that digit is not counted as sent.
- Store writes:
  - A write is accepted only when all of these hold: state IDLE, wr_idx<NUM_DIGITS, wr_digit<=9.
  - An accepted write updates the store at the next edge.
  - Any other wr_en cycle leaves the store unchanged and pulses err in the next cycle.
  - A write and a start in the same IDLE cycle are both accepted. The written value is visible on the first presented digit.
- digit is derived from the registered store and registered idx, gated to 0 when digit_valid=0. There are no combinational paths from inputs to outputs.

Decomposition:
- Package phone_dial_pkg holds:
  - constants NUM_DIGITS_DEF, DIGIT_W, MAX_DIGIT=9
  - state enum type (IDLE/PRESENT/GAP/DONE)
  - DEFAULT_NUMBER constant array
- One sub-module, dial_gap_timer: an 8-bit loadable down-counter with load, value and expire outputs. It is instantiated once for the GAP state.

Test Plan:
- Reset, then start with digit_ready held 1 and GAP_CYCLES=4: digits 9,8,6,6,5,6,2,4,1,8 on consecutive valid windows, each valid one cycle with 4 low cycles between; done pulses once; busy high for 10+9*4=46 cycles.
- digit_ready held low for 7 cycles on idx=3: digit stays 6 with valid high, idx stays 3; transfer on the first ready cycle; no digit skipped or repeated.
- Write wr_idx=2, wr_digit=7 in IDLE, then start: third digit presented is 7. Write wr_digit=10 gives err=1 with the store unchanged. Write wr_idx=12 gives err=1. Write while busy gives err=1.
- Abort asserted in the same cycle as the transfer of idx=5: next cycle IDLE, valid=0, busy=0, idx=0, no done. A following start replays from digit 9.
- start pulsed repeatedly during playback: sequence unaffected, exactly one done.
- rst asserted in GAP after idx=4 with a prior write to idx 0 (value 3): all outputs return to reset values and the store reverts, so the next playback starts with 9.

Source files
------------

// File: rtl/phone_dial_pkg.sv
// Shared types and constants for the phone dial sequencer.
// The default number is packed with digit index 0 in the least-significant nibble.
package phone_dial_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 10;
  localparam int unsigned DIGIT_W        = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StGap,
    StDone
  } dial_state_e;

  // Sixteen slots so any 4-bit index is in range; slots past the number are zero.
  localparam logic [15:0][DIGIT_W-1:0] DEFAULT_NUMBER = {
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd8, 4'd1, 4'd4, 4'd2, 4'd6, 4'd5, 4'd6, 4'd6, 4'd8, 4'd9
  };

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/dial_gap_timer.sv
// 8-bit loadable down-counter that times the idle gap between digits.
// expire flags the final gap cycle so the caller can leave the gap on the next edge.
module dial_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] value,
  output logic       expire
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value  = count_q;
  assign expire = (count_q == 8'd1);

endmodule

// File: rtl/phone_dial_sequencer.sv
// Plays a stored phone number one digit per valid/ready transfer with a fixed idle gap.
// All outputs are decoded from registers; the store is only writable while idle.
module phone_dial_sequencer
  import phone_dial_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               wr_en,
  input  logic [3:0]         wr_idx,
  input  logic [DIGIT_W-1:0] wr_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  input  logic               digit_ready,
  output logic [3:0]         idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [3:0] LastIdx    = 4'(NUM_DIGITS - 1);
  localparam logic [4:0] NumDigitsW = 5'(NUM_DIGITS);
  localparam logic [7:0] GapLoad    = 8'(GAP_CYCLES);

  dial_state_e                 state_q, state_d;
  logic [3:0]                  idx_q, idx_d;
  logic [15:0][DIGIT_W-1:0]    store_q, store_d;
  logic                        err_q, err_d;
  logic                        wr_ok;
  logic                        gap_load, gap_expire;
  logic [7:0]                  gap_value;

  assign wr_ok = wr_en && (state_q == StIdle) && ({1'b0, wr_idx} < NumDigitsW) &&
                 is_bcd(wr_digit);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    store_d  = store_q;
    gap_load = 1'b0;
    err_d    = wr_en && !wr_ok;
    if (wr_ok) begin
      store_d[wr_idx] = wr_digit;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPresent;
          idx_d   = '0;
        end
      end
      StPresent: begin
        // Abort wins over a same-cycle transfer; that digit is not counted.
        if (abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (digit_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            state_d  = StGap;
            idx_d    = idx_q + 4'd1;
            gap_load = 1'b1;
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (gap_expire) begin
          state_d = StPresent;
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      store_q <= DEFAULT_NUMBER;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  dial_gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GapLoad),
    .dec      (state_q == StGap),
    .value    (gap_value),
    .expire   (gap_expire)
  );

  // A zero count while gapping would stall the sequencer forever.
  gap_count_live: assert property (@(posedge clk) disable iff (rst)
    (state_q == StGap) |-> (gap_value != 8'd0));

  assign digit_valid = (state_q == StPresent);
  assign digit       = digit_valid ? store_q[idx_q] : '0;
  assign idx         = idx_q;
  assign busy        = (state_q == StPresent) || (state_q == StGap);
  assign done        = (state_q == StDone);
  assign err         = err_q;

endmodule

// File: tb/tb_phone_dial_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized playbacks scored against a digit-list / gap-count reference model.
module tb_phone_dial_sequencer;

  localparam int Nd  = 10;
  localparam int Gap = 4;
  localparam int DefNum [Nd] = '{9, 8, 6, 6, 5, 6, 2, 4, 1, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, abort = 1'b0, wr_en = 1'b0, digit_ready = 1'b0;
  logic [3:0] wr_idx = '0, wr_digit = '0;
  logic [3:0] digit, idx;
  logic       digit_valid, busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;
  int mstore [Nd];

  phone_dial_sequencer #(
    .NUM_DIGITS (Nd),
    .GAP_CYCLES (Gap)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_digit    (wr_digit),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .idx         (idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst, start, abort, wr_en;
    logic [3:0] wr_idx, wr_digit;
    logic       ready;
    logic       valid;
    logic [3:0] digit, idx;
    logic       busy, done, err;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  function automatic int pack(logic v, logic [3:0] d, logic [3:0] i, logic b, logic dn,
                              logic e);
    return {20'd0, v, d, i, b, dn, e};
  endfunction

  function automatic int outs();
    return pack(digit_valid, digit, idx, busy, done, err);
  endfunction

  function automatic vec_t mk(logic r, logic s, logic a, logic w, int wi, int wd, logic rdy,
                              logic v, int d, int i, logic b, logic dn, logic e);
    vec_t t;
    t.rst = r; t.start = s; t.abort = a; t.wr_en = w;
    t.wr_idx = 4'(wi); t.wr_digit = 4'(wd); t.ready = rdy;
    t.valid = v; t.digit = 4'(d); t.idx = 4'(i); t.busy = b; t.done = dn; t.err = e;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Nd; i++) mstore[i] = DefNum[i];
  endtask

  function automatic bit legal(int wi, int wd);
    return (wi < Nd) && (wd <= 9);
  endfunction

  task automatic do_write(input int wi, input int wd);
    wr_en = 1'b1; wr_idx = 4'(wi); wr_digit = 4'(wd);
    tick();
    wr_en = 1'b0;
    check($sformatf("write(%0d,%0d) err", wi, wd), int'(err), int'(!legal(wi, wd)));
    if (legal(wi, wd)) mstore[wi] = wd;
  endtask

  // Plays one full number from IDLE and scores it: every valid digit must match the
  // snapshot taken at start, gaps must be exactly Gap cycles, busy spans valid+gap cycles.
  task automatic play(input string name, input int ready_pct, input int stall_idx,
                      input int stall_len, input bit spam, input bit wr, input int wi,
                      input int wd);
    int snap [Nd];
    int ptr = 0, cyc = 0, valid_cyc = 0, busy_cyc = 0, stalls = 0, held = 0, low = 0;
    int bad_digit = 0, bad_gap = 0, bad_done = 0, extra_done = 0;
    bit fin = 0, counting = 0, rdy;
    start = 1'b1;
    if (wr) begin
      wr_en = 1'b1; wr_idx = 4'(wi); wr_digit = 4'(wd);
      if (legal(wi, wd)) mstore[wi] = wd;
    end
    snap = mstore;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (wr) check({name, " start-write err"}, int'(err), int'(!legal(wi, wd)));
    while (!fin && cyc < 1000) begin
      cyc++;
      if (digit_valid) begin
        valid_cyc++;
        if (ptr >= Nd || int'(digit) != snap[ptr] || int'(idx) != ptr) bad_digit++;
        if (counting && low != Gap) bad_gap++;
        counting = 0;
        if (ptr == stall_idx) held++;
        if (ptr == stall_idx && stalls < stall_len) begin
          rdy = 1'b0;
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
        end
        if (!rdy) stalls++;
        digit_ready = rdy;
        if (rdy) begin
          ptr++;
          counting = (ptr < Nd);
          low = 0;
        end
      end else begin
        digit_ready = 1'($urandom_range(1));
        if (counting) low++;
        if (done) begin
          if (busy || idx != 4'd0 || digit != 4'd0) bad_done++;
          fin = 1;
        end
      end
      if (busy) busy_cyc++;
      start = spam ? (done ? 1'b1 : 1'($urandom_range(1))) : 1'b0;
      tick();
    end
    start = 1'b0;
    digit_ready = 1'b0;
    check({name, " finished"}, int'(fin), 1);
    check({name, " idle after done"}, outs(), pack(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done || busy || digit_valid) extra_done++;
    end
    check({name, " digits sent"}, ptr, Nd);
    check({name, " digit errors"}, bad_digit, 0);
    check({name, " gap errors"}, bad_gap, 0);
    check({name, " done state errors"}, bad_done, 0);
    check({name, " activity after done"}, extra_done, 0);
    check({name, " valid cycles"}, valid_cyc, Nd + stalls);
    check({name, " busy cycles"}, busy_cyc, valid_cyc + (Nd - 1) * Gap);
    if (stall_len > 0 && ready_pct == 100) check({name, " held cycles"}, held, stall_len + 1);
  endtask

  initial begin
    int guard;
    // inputs: rst start abort wr_en wr_idx wr_digit ready | valid digit idx busy done err
    vecs.push_back(mk(1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  2,  7, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  2, 10, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 12,  5, 0,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0,  0, 0,  1, 9, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 1,  0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0,  1, 1,  0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0,  0, 1,  0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  1, 8, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 1,  0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  1, 7, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0,  0, 1,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0,  0, 0,  1, 9, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,  0,  0, 0,  1, 9, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0,  0, 0,  0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
      wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx; wr_digit = vecs[i].wr_digit;
      digit_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d {valid,digit,idx,busy,done,err}", i), outs(),
            pack(vecs[i].valid, vecs[i].digit, vecs[i].idx, vecs[i].busy, vecs[i].done,
                 vecs[i].err));
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; digit_ready = 1'b0;
    model_reset();

    play("full_ready", 100, -1, 0, 0, 0, 0, 0);
    play("stall_idx3", 100, 3, 7, 0, 0, 0, 0);
    do_write(2, 7);
    do_write(4, 10);
    do_write(12, 1);
    play("after_write", 100, -1, 0, 0, 0, 0, 0);
    play("write_with_start", 100, -1, 0, 0, 1, 5, 3);
    play("start_spam", 100, -1, 0, 1, 0, 0, 0);

    // Abort in the same cycle as the transfer of idx 5.
    start = 1'b1; digit_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(digit_valid && idx == 4'd5) && guard < 200) begin
      guard++;
      tick();
    end
    check("abort reached idx5", int'(guard < 200), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0; digit_ready = 1'b0;
    check("abort outputs", outs(), pack(0, 0, 0, 0, 0, 0));
    guard = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done || busy) guard++;
    end
    check("abort no done", guard, 0);
    play("replay_after_abort", 100, -1, 0, 0, 0, 0, 0);

    // Reset during the gap after idx 4, with a prior write that must be lost.
    do_write(0, 3);
    start = 1'b1; digit_ready = 1'b1;
    tick();
    start = 1'b0;
    check("pre-reset first digit", int'(digit), 3);
    guard = 0;
    while (!(busy && !digit_valid && idx == 4'd5) && guard < 200) begin
      guard++;
      tick();
    end
    check("reset reached gap idx5", int'(guard < 200), 1);
    rst = 1'b1;
    tick();
    check("reset outputs", outs(), pack(0, 0, 0, 0, 0, 0));
    rst = 1'b0; digit_ready = 1'b0;
    model_reset();
    tick();
    play("after_reset", 100, -1, 0, 0, 0, 0, 0);

    for (int it = 0; it < 15; it++) begin
      int nw;
      nw = $urandom_range(3);
      for (int w = 0; w < nw; w++) do_write($urandom_range(11), $urandom_range(11));
      play($sformatf("rand%0d", it), $urandom_range(100, 30), $urandom_range(9),
           $urandom_range(5), 1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(11), $urandom_range(11));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
